riscv_fetch: RTL and testbench

Instruction-fetch initiator for the RISC-V core: owns the program counter and issues read requests on the instruction-memory port (`riscv_memory` iaddr/ird side, 1-cycle read latency). It tags each returned word with its PC and buffers it in a small FIFO for the decoder, using a valid/ready handshake. On a taken branch or jump it redirects the PC and flushes both buffered and in-flight fetches.

---
 rtl/riscv_fetch.sv | 121 ++++++++++++
 tb/tb_riscv_fetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle-latency memory reads
// and queues {pc, opcode} pairs for the decoder; redirects flush everything.
module riscv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [31:0] iaddr_o,
    output logic        ird_o,
    input  logic [31:0] irdata_i,
    input  logic        branch_taken_i,
    input  logic [31:0] jump_addr_i,
    output logic        if_valid_o,
    output logic [31:0] if_opcode_o,
    output logic [31:0] if_pc_o,
    input  logic        id_ready_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   last_pc_q, last_pc_d;
    logic [31:0]   last_op_q, last_op_d;

    logic [31:0] mem_pc [DEPTH];
    logic [31:0] mem_op [DEPTH];

    logic        issue;
    logic        push;
    logic        pop;
    logic [CW:0] used;
    logic [31:0] head_pc;
    logic [31:0] head_op;

    // Credit includes the outstanding read but ignores a same-cycle pop,
    // keeping id_ready_i off the path to ird_o.
    assign used  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue = !reset_i && !branch_taken_i && (used < DEPTH_L);
    assign push  = inflight_q && !branch_taken_i;
    assign pop   = if_valid_o && id_ready_i && !branch_taken_i;

    assign head_pc = mem_pc[rd_ptr_q];
    assign head_op = mem_op[rd_ptr_q];

    assign ird_o       = issue;
    assign iaddr_o     = fetch_pc_q;
    assign if_valid_o  = (count_q != '0);
    assign if_pc_o     = if_valid_o ? head_pc : last_pc_q;
    assign if_opcode_o = if_valid_o ? head_op : last_op_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        last_pc_d     = if_valid_o ? head_pc : last_pc_q;
        last_op_d     = if_valid_o ? head_op : last_op_q;

        if (branch_taken_i) begin
            fetch_pc_d = {jump_addr_i[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            last_pc_q     <= 32'h0;
            last_op_q     <= 32'h0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            last_pc_q     <= last_pc_d;
            last_op_q     <= last_op_d;
        end
    end

    // Buffer storage carries no reset; entries are only visible while count_q > 0.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc[wr_ptr_q] <= inflight_pc_q;
            mem_op[wr_ptr_q] <= irdata_i;
        end
    end
endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: streaming, back-pressure, redirects, PC wrap
// and asynchronous reset, against a 1-cycle-latency instruction memory model.
module tb_riscv_fetch;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] iaddr_o;
    logic        ird_o;
    logic [31:0] irdata_i;
    logic        branch_taken_i;
    logic [31:0] jump_addr_i;
    logic        if_valid_o;
    logic [31:0] if_opcode_o;
    logic [31:0] if_pc_o;
    logic        id_ready_i;

    int n_cmp = 0;
    int n_err = 0;

    riscv_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .iaddr_o        (iaddr_o),
        .ird_o          (ird_o),
        .irdata_i       (irdata_i),
        .branch_taken_i (branch_taken_i),
        .jump_addr_i    (jump_addr_i),
        .if_valid_o     (if_valid_o),
        .if_opcode_o    (if_opcode_o),
        .if_pc_o        (if_pc_o),
        .id_ready_i     (id_ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory returns the addressed word one cycle after an accepted request.
    always @(posedge clk_i) begin
        if (ird_o) irdata_i <= mem_word(iaddr_o);
        else       irdata_i <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_v"},  {31'b0, if_valid_o}, 32'd1);
        chk({tag, "_pc"}, if_pc_o, pc);
        chk({tag, "_op"}, if_opcode_o, mem_word(pc));
    endtask

    initial begin
        int          n_req;
        logic [31:0] last_addr;

        reset_i        = 1'b1;
        branch_taken_i = 1'b0;
        jump_addr_i    = 32'h0;
        id_ready_i     = 1'b1;
        #2;
        chk("rst_ird",   {31'b0, ird_o}, 32'd0);
        chk("rst_iaddr", iaddr_o, 32'h0);
        chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
        chk("rst_op",    if_opcode_o, 32'h0);
        chk("rst_pc",    if_pc_o, 32'h0);

        // Streaming with the decoder always ready.
        do_reset();
        chk("first_ird",   {31'b0, ird_o}, 32'd1);
        chk("first_iaddr", iaddr_o, 32'h0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("stream_iaddr", iaddr_o, 32'(4 * (k + 1)));
            if (k == 0) chk("stream_nv", {31'b0, if_valid_o}, 32'd0);
            else        chk_head("stream", 32'(4 * (k - 1)));
        end

        // Redirect to 0x0C while 0x20 is requested and 0x1C is in flight.
        branch_taken_i = 1'b1;
        jump_addr_i    = 32'h0000_000C;
        #1;
        chk("br_ird", {31'b0, ird_o}, 32'd0);
        step();
        branch_taken_i = 1'b0;
        #1;
        chk("br_valid0", {31'b0, if_valid_o}, 32'd0);
        chk("br_hold_pc", if_pc_o, 32'h18);
        chk("br_ird1", {31'b0, ird_o}, 32'd1);
        chk("br_iaddr", iaddr_o, 32'h0C);
        step();
        chk("br_valid1", {31'b0, if_valid_o}, 32'd0);
        step();
        chk_head("br_t0", 32'h0C);
        step();
        chk_head("br_t1", 32'h10);

        // Misaligned target is word-aligned.
        branch_taken_i = 1'b1;
        jump_addr_i    = 32'h0000_0013;
        step();
        branch_taken_i = 1'b0;
        #1;
        chk("align_iaddr", iaddr_o, 32'h10);

        // Back-to-back redirects: the last one wins.
        branch_taken_i = 1'b1;
        jump_addr_i    = 32'h0000_0040;
        step();
        jump_addr_i    = 32'h0000_0080;
        step();
        branch_taken_i = 1'b0;
        #1;
        chk("b2b_iaddr", iaddr_o, 32'h80);
        chk("b2b_ird", {31'b0, ird_o}, 32'd1);
        chk("b2b_v0", {31'b0, if_valid_o}, 32'd0);
        step();
        chk("b2b_v1", {31'b0, if_valid_o}, 32'd0);
        step();
        chk_head("b2b_t0", 32'h80);
        step();
        chk_head("b2b_t1", 32'h84);

        // PC wrap at the top of the address space.
        branch_taken_i = 1'b1;
        jump_addr_i    = 32'hFFFF_FFF8;
        step();
        branch_taken_i = 1'b0;
        #1;
        chk("wrap_a0", iaddr_o, 32'hFFFF_FFF8);
        step();
        chk("wrap_a1", iaddr_o, 32'hFFFF_FFFC);
        step();
        chk("wrap_a2", iaddr_o, 32'h0000_0000);
        chk_head("wrap_h0", 32'hFFFF_FFF8);
        step();
        chk_head("wrap_h1", 32'hFFFF_FFFC);
        step();
        chk_head("wrap_h2", 32'h0000_0000);

        // Back-pressure: exactly DEPTH requests, then release in order.
        id_ready_i = 1'b0;
        do_reset();
        n_req     = 0;
        last_addr = 32'hFFFF_FFFF;
        for (int c = 0; c < 10; c++) begin
            if (ird_o) begin
                n_req++;
                last_addr = iaddr_o;
            end
            step();
        end
        chk("stall_nreq", 32'(n_req), 32'd4);
        chk("stall_last", last_addr, 32'h0C);
        chk("stall_ird", {31'b0, ird_o}, 32'd0);
        id_ready_i = 1'b1;
        #1;
        for (int j = 0; j < 6; j++) begin
            chk_head("drain", 32'(4 * j));
            step();
        end

        // Asynchronous reset with a full buffer.
        id_ready_i = 1'b0;
        repeat (8) step();
        chk("full_valid", {31'b0, if_valid_o}, 32'd1);
        chk("full_ird", {31'b0, ird_o}, 32'd0);
        reset_i = 1'b1;
        #1;
        chk("arst_valid", {31'b0, if_valid_o}, 32'd0);
        chk("arst_ird", {31'b0, ird_o}, 32'd0);
        chk("arst_iaddr", iaddr_o, 32'h0);
        chk("arst_op", if_opcode_o, 32'h0);
        chk("arst_pc", if_pc_o, 32'h0);
        step();
        step();
        id_ready_i = 1'b1;
        reset_i    = 1'b0;
        #1;
        chk("rel_ird", {31'b0, ird_o}, 32'd1);
        chk("rel_iaddr", iaddr_o, 32'h0);
        step();
        step();
        chk_head("rel_h0", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
